// File: rtl/melody_pkg.sv
// ============================================================================
// Module   : melody_pkg
// Purpose  : Shared constants for the melody sequencer. Contains the score
//            entry field layout, the octave codes, the FSM state encoding,
//            the mid-octave base tone periods (50 MHz clock) and the
//            note/octave to period helper.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package melody_pkg;

    // Score entry layout: [2:0] note, [4:3] octave, [7:5] duration-1 beats
    localparam int c_NOTE_LSB = 0;
    localparam int c_OCT_LSB  = 3;
    localparam int c_DUR_LSB  = 5;

    // Octave codes; OCT_END together with note 0 marks the end of the score
    localparam logic [1:0] c_OCT_LOW  = 2'd0;
    localparam logic [1:0] c_OCT_MID  = 2'd1;
    localparam logic [1:0] c_OCT_HIGH = 2'd2;
    localparam logic [1:0] c_OCT_END  = 2'd3;

    // FSM state encoding
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FETCH   = 3'd1;
    localparam logic [2:0] c_ST_DECODE  = 3'd2;
    localparam logic [2:0] c_ST_NOTE    = 3'd3;
    localparam logic [2:0] c_ST_GAP     = 3'd4;
    localparam logic [2:0] c_ST_END_CHK = 3'd5;
    localparam logic [2:0] c_ST_DONE    = 3'd6;

    // Mid-octave base periods in clock cycles
    localparam logic [18:0] c_BASE_DO = 19'd190839;
    localparam logic [18:0] c_BASE_RE = 19'd170067;
    localparam logic [18:0] c_BASE_MI = 19'd151514;
    localparam logic [18:0] c_BASE_FA = 19'd143265;
    localparam logic [18:0] c_BASE_SO = 19'd127550;
    localparam logic [18:0] c_BASE_LA = 19'd113635;
    localparam logic [18:0] c_BASE_XI = 19'd101214;

    // Tone period for a note in a given octave; a rest yields 0.
    // Octave code 3 with a pitched note is played as the mid octave.
    function automatic logic [18:0] note_period(input logic [2:0] note,
                                                input logic [1:0] oct);
        logic [18:0] base;
        logic [18:0] result;
        case (note)
            3'd1:    base = c_BASE_DO;
            3'd2:    base = c_BASE_RE;
            3'd3:    base = c_BASE_MI;
            3'd4:    base = c_BASE_FA;
            3'd5:    base = c_BASE_SO;
            3'd6:    base = c_BASE_LA;
            3'd7:    base = c_BASE_XI;
            default: base = 19'd0;
        endcase
        case (oct)
            c_OCT_LOW:  result = base << 1;
            c_OCT_HIGH: result = base >> 1;
            default:    result = base;
        endcase
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/melody_rom.sv
// ============================================================================
// Module   : melody_rom
// Purpose  : Synchronous 2^ADDR_W x 8 score ROM with one cycle read latency.
//            Contents come from the SCORE parameter, entry 0 in the least
//            significant byte.
// Ports    : i_clk   clock
//            i_addr  read address
//            o_data  registered entry at i_addr from the previous edge
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module melody_rom #(
    parameter int                        ADDR_W = 5,
    parameter logic [(8<<ADDR_W)-1:0]    SCORE  = {(1<<ADDR_W){8'h18}}
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [7:0]        o_data
);

    logic [7:0] r_data;

    always_ff @(posedge i_clk) begin
        r_data <= SCORE[i_addr*8 +: 8];
    end

    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/melody_seq.sv
// ============================================================================
// Module   : melody_seq
// Purpose  : Score sequencer feeding the PWM tone generator. Walks the score
//            ROM, times each note in beats followed by a silent gap, and
//            presents registered period/duty/enable plus a note-start strobe.
// Ports    : i_sysclk, i_sysrst (sync, active high)
//            i_play  level: run score / abort to idle
//            i_loop  sampled at end of score: restart from address 0
//            o_period, o_duty, o_tone_en, o_note_start  tone generator side
//            o_addr, o_busy, o_done                     status
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module melody_seq
    import melody_pkg::*;
#(
    parameter logic [24:0]               BEAT_CNT = 25'd24999999,
    parameter logic [21:0]               GAP_CNT  = 22'd2499999,
    parameter int                        ADDR_W   = 5,
    parameter logic [(8<<ADDR_W)-1:0]    SCORE    = {(1<<ADDR_W){8'h18}}
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic              i_play,
    input  logic              i_loop,
    output logic [18:0]       o_period,
    output logic [17:0]       o_duty,
    output logic              o_tone_en,
    output logic              o_note_start,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_busy,
    output logic              o_done
);

    logic [2:0]        r_state;
    logic              r_play;
    logic [24:0]       r_beat;      // cycles left in beat, reused for the gap
    logic [2:0]        r_beats;     // beats left after the current one
    logic [18:0]       r_period;
    logic [17:0]       r_duty;
    logic              r_tone_en;
    logic              r_note_start;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_done;

    logic [7:0]        w_entry;
    logic [2:0]        w_note;
    logic [1:0]        w_oct;
    logic [2:0]        w_dur;
    logic [18:0]       w_period;
    logic              w_end;
    logic              w_active;

    melody_rom #(
        .ADDR_W (ADDR_W),
        .SCORE  (SCORE)
    ) u_rom (
        .i_clk  (i_sysclk),
        .i_addr (r_addr),
        .o_data (w_entry)
    );

    assign w_note   = w_entry[c_NOTE_LSB +: 3];
    assign w_oct    = w_entry[c_OCT_LSB  +: 2];
    assign w_dur    = w_entry[c_DUR_LSB  +: 3];
    assign w_period = note_period(w_note, w_oct);
    assign w_end    = (w_note == 3'd0) && (w_oct == c_OCT_END);

    // States in which a low i_play aborts playback
    assign w_active = (r_state == c_ST_FETCH)  || (r_state == c_ST_DECODE) ||
                      (r_state == c_ST_NOTE)   || (r_state == c_ST_GAP)    ||
                      (r_state == c_ST_END_CHK);

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_state      <= c_ST_IDLE;
            r_play       <= 1'b0;
            r_beat       <= '0;
            r_beats      <= '0;
            r_period     <= '0;
            r_duty       <= '0;
            r_tone_en    <= 1'b0;
            r_note_start <= 1'b0;
            r_addr       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_play       <= i_play;
            r_note_start <= 1'b0;
            if (w_active && !i_play) begin
                r_state   <= c_ST_IDLE;
                r_period  <= '0;
                r_duty    <= '0;
                r_tone_en <= 1'b0;
                r_addr    <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        // Start is taken from the registered copy of i_play,
                        // so FETCH follows one cycle after the request.
                        if (r_play && i_play) begin
                            r_state <= c_ST_FETCH;
                            r_addr  <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    c_ST_FETCH: begin
                        r_state <= c_ST_DECODE;
                    end
                    c_ST_DECODE: begin
                        if (w_end) begin
                            r_state <= c_ST_END_CHK;
                        end else begin
                            r_state      <= c_ST_NOTE;
                            r_period     <= w_period;
                            r_duty       <= w_period[18:1];
                            r_tone_en    <= (w_note != 3'd0);
                            r_note_start <= 1'b1;
                            r_beat       <= BEAT_CNT;
                            r_beats      <= w_dur;
                        end
                    end
                    c_ST_NOTE: begin
                        if (r_beat != 25'd0) begin
                            r_beat <= r_beat - 25'd1;
                        end else if (r_beats != 3'd0) begin
                            r_beats <= r_beats - 3'd1;
                            r_beat  <= BEAT_CNT;
                        end else begin
                            r_state   <= c_ST_GAP;
                            r_period  <= '0;
                            r_duty    <= '0;
                            r_tone_en <= 1'b0;
                            r_beat    <= {3'b000, GAP_CNT};
                        end
                    end
                    c_ST_GAP: begin
                        if (r_beat != 25'd0) begin
                            r_beat <= r_beat - 25'd1;
                        end else if (r_addr == {ADDR_W{1'b1}}) begin
                            r_state <= c_ST_END_CHK;
                        end else begin
                            r_state <= c_ST_FETCH;
                            r_addr  <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end
                    c_ST_END_CHK: begin
                        if (i_loop) begin
                            r_state <= c_ST_FETCH;
                            r_addr  <= '0;
                        end else begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    c_ST_DONE: begin
                        if (!i_play) begin
                            r_state <= c_ST_IDLE;
                            r_done  <= 1'b0;
                            r_addr  <= '0;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_period     = r_period;
    assign o_duty       = r_duty;
    assign o_tone_en    = r_tone_en;
    assign o_note_start = r_note_start;
    assign o_addr       = r_addr;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

`default_nettype wire
